// File: rtl/sram_like_responder.sv
// Serves the core's fetch and data sram-like ports from one single-ported synchronous RAM.
// Accesses are serialised (data first) with LAT wait states; results are held until longest_stall falls.
module sram_like_responder #(
  parameter int AW  = 16,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inst_en,
  input  logic [31:0]   inst_addr,
  output logic [31:0]   inst_rdata,
  output logic          i_stall,
  input  logic          data_en,
  input  logic [3:0]    data_wen,
  input  logic [31:0]   data_addr,
  input  logic [31:0]   data_wdata,
  output logic [31:0]   data_rdata,
  output logic          d_stall,
  input  logic          longest_stall,
  output logic          ram_en,
  output logic [3:0]    ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [3:0] LAT_LOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          sel_q, sel_d;        // 1: data port owns the access
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    wen_q, wen_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d;
  logic [31:0]   data_rdata_q, data_rdata_d;
  logic          ram_en_q, ram_en_d;
  logic [3:0]    ram_wen_q, ram_wen_d;
  logic          i_pend, d_pend;
  logic          set_i_done, set_d_done;
  logic          unused_addr_bits;

  assign d_pend = data_en & ~d_done_q;
  assign i_pend = inst_en & ~i_done_q;
  assign unused_addr_bits = ^{inst_addr[31:AW+2], inst_addr[1:0], data_addr[31:AW+2], data_addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_pend || i_pend) begin
          state_d = (LAT > 0) ? WAIT : ACC;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACC;
        end else begin
          state_d = WAIT;
        end
      end
      ACC:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latching, wait counter, response capture and done flags.
  always_comb begin
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    set_i_done   = 1'b0;
    set_d_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_pend) begin
          sel_d   = 1'b1;
          addr_d  = data_addr[AW+1:2];
          wen_d   = data_wen;
          wdata_d = data_wdata;
          cnt_d   = LAT_LOAD;
        end else if (i_pend) begin
          sel_d   = 1'b0;
          addr_d  = inst_addr[AW+1:2];
          wen_d   = 4'd0;
          cnt_d   = LAT_LOAD;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ACC: begin
        cnt_d = cnt_q;
      end
      RESP: begin
        if (sel_q) begin
          data_rdata_d = ram_rdata;
          set_d_done   = 1'b1;
        end else begin
          inst_rdata_d = ram_rdata;
          set_i_done   = 1'b1;
        end
      end
      default: begin
        cnt_d = 4'd0;
      end
    endcase
    // A low longest_stall wins over a completion in the same cycle.
    if (longest_stall) begin
      i_done_d = i_done_q | set_i_done;
      d_done_d = d_done_q | set_d_done;
    end else begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end
  end

  always_comb begin
    ram_en_d = (state_d == ACC);
    if (state_d == ACC) begin
      ram_wen_d = wen_d;
    end else begin
      ram_wen_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q        <= 4'd0;
      sel_q        <= 1'b0;
      addr_q       <= '0;
      wen_q        <= 4'd0;
      wdata_q      <= 32'd0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
      ram_en_q     <= 1'b0;
      ram_wen_q    <= 4'd0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      ram_en_q     <= ram_en_d;
      ram_wen_q    <= ram_wen_d;
    end
  end

  assign i_stall    = i_pend;
  assign d_stall    = d_pend;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign ram_en     = ram_en_q;
  assign ram_wen    = ram_wen_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: four instances (LAT 2, 0, 1, 15) share request inputs, each with its own RAM.
// Expectations come from fixed vectors, latency formulas and a word-array memory model.
module tb_sram_like_responder;

  localparam int N = 4;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 2;
      1:       return 0;
      2:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic [31:0] init_word(input int i);
    case (i)
      'h10:    return 32'h2408_0001;
      'h40:    return 32'hCAFE_0100;
      'h00:    return 32'h3C01_0000;
      'h80:    return 32'h1122_3344;
      default: return {16'(i), 16'(i) ^ 16'hA5A5};
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_en, data_en, hold;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wen;
  logic [7:0]  probe_idx;

  logic [31:0] inst_rdata_w [N];
  logic [31:0] data_rdata_w [N];
  logic        i_stall_w [N];
  logic        d_stall_w [N];
  logic        ls_w [N];
  logic        ram_en_w [N];
  logic [3:0]  ram_wen_w [N];
  logic [15:0] ram_addr_w [N];
  logic [31:0] ram_wdata_w [N];
  int unsigned en_cnt_w [N];
  logic [31:0] mem_probe_w [N];

  logic [31:0] model [256];
  int          n_checks = 0;
  int          n_fail = 0;
  int          d_fall [N];
  int          i_fall [N];
  int          en_first0;
  logic [15:0] addr_first0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [31:0] mem [256];
    logic [31:0] rd_q = 32'd0;
    int unsigned en_edges = 0;

    sram_like_responder #(.AW(16), .LAT(lat_of(g))) u_dut (
      .clk(clk), .resetn(resetn),
      .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata_w[g]), .i_stall(i_stall_w[g]),
      .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rdata(data_rdata_w[g]), .d_stall(d_stall_w[g]), .longest_stall(ls_w[g]),
      .ram_en(ram_en_w[g]), .ram_wen(ram_wen_w[g]), .ram_addr(ram_addr_w[g]),
      .ram_wdata(ram_wdata_w[g]), .ram_rdata(rd_q)
    );

    assign ls_w[g]        = i_stall_w[g] | d_stall_w[g] | hold;
    assign en_cnt_w[g]    = en_edges;
    assign mem_probe_w[g] = mem[probe_idx];

    initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);

    always @(posedge clk) begin
      if (ram_en_w[g]) begin
        rd_q <= mem[ram_addr_w[g][7:0]];
        for (int b = 0; b < 4; b++)
          if (ram_wen_w[g][b]) mem[ram_addr_w[g][7:0]][8*b +: 8] <= ram_wdata_w[g][8*b +: 8];
        en_edges <= en_edges + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_all(input int budget);
    bit busy;
    busy = 1'b1;
    for (int c = 0; c < budget && busy; c++) begin
      @(negedge clk);
      busy = 1'b0;
      for (int g = 0; g < N; g++) if (i_stall_w[g] || d_stall_w[g]) busy = 1'b1;
    end
    check("wait_all_busy", 32'(busy), 32'd0);
  endtask

  // One access (or a data+fetch pair) on every instance, checked against latency formulas and expected words.
  task automatic run_txn(input bit den, input bit ien, input logic [3:0] wen, input logic [31:0] daddr,
                         input logic [31:0] wdata, input logic [31:0] iaddr,
                         input logic [31:0] exp_d, input logic [31:0] exp_i);
    int unsigned base [N];
    bit          done;
    int          l;
    @(posedge clk); #1;
    for (int g = 0; g < N; g++) begin
      base[g] = en_cnt_w[g]; d_fall[g] = -1; i_fall[g] = -1;
    end
    en_first0 = -1; addr_first0 = 16'd0;
    data_en = den; inst_en = ien; data_wen = wen; data_addr = daddr; data_wdata = wdata;
    inst_addr = iaddr; hold = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (den) check("d_stall_c0", 32'(d_stall_w[0]), 32'd1);
        else     check("i_stall_c0", 32'(i_stall_w[0]), 32'd1);
      end
      if (c == 1 && den) begin
        data_addr = ~daddr; data_wdata = ~wdata;
      end
      if (en_first0 < 0 && ram_en_w[0]) begin
        en_first0 = c; addr_first0 = ram_addr_w[0];
      end
      done = 1'b1;
      for (int g = 0; g < N; g++) begin
        if (den && d_fall[g] < 0 && !d_stall_w[g]) d_fall[g] = c;
        if (ien && i_fall[g] < 0 && !i_stall_w[g]) i_fall[g] = c;
        if ((den && d_fall[g] < 0) || (ien && i_fall[g] < 0)) done = 1'b0;
      end
    end
    for (int g = 0; g < N; g++) begin
      l = lat_of(g);
      if (den) check($sformatf("d_fall_lat%0d", l), 32'(d_fall[g]), 32'(l + 3));
      if (ien) check($sformatf("i_fall_lat%0d", l), 32'(i_fall[g]), den ? 32'(2*l + 6) : 32'(l + 3));
      if (den && wen == 4'd0) check($sformatf("data_rdata_lat%0d", l), data_rdata_w[g], exp_d);
      if (ien) check($sformatf("inst_rdata_lat%0d", l), inst_rdata_w[g], exp_i);
    end
    check("ram_en_cycle", 32'(en_first0), 32'(lat_of(0) + 1));
    check("ram_addr", 32'(addr_first0), den ? 32'(daddr[17:2]) : 32'(iaddr[17:2]));
    @(posedge clk); #1;
    data_en = 1'b0; inst_en = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < N; g++)
      check($sformatf("ram_en_count_lat%0d", lat_of(g)), en_cnt_w[g] - base[g], 32'(int'(den) + int'(ien)));
    if (den && wen != 4'd0) model[daddr[9:2]] = merge(model[daddr[9:2]], wdata, wen);
  endtask

  typedef struct {
    bit          den;
    bit          ien;
    logic [3:0]  wen;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] iaddr;
    logic [31:0] exp_d;
    logic [31:0] exp_i;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] r_hold, exp_d, exp_i, daddr_r, iaddr_r;
  int unsigned base0;
  int          kind;
  logic [3:0]  wen_r;

  initial begin
    for (int i = 0; i < 256; i++) model[i] = init_word(i);
    vecs[0] = '{1'b0, 1'b1, 4'd0,     32'h0,         32'h0,         32'h40, 32'h0,         32'h2408_0001};
    vecs[1] = '{1'b1, 1'b1, 4'd0,     32'h100,       32'h0,         32'h0,  32'hCAFE_0100, 32'h3C01_0000};
    vecs[2] = '{1'b1, 1'b0, 4'b0010,  32'h200,       32'h0000_AB00, 32'h0,  32'h0,         32'h0};
    vecs[3] = '{1'b1, 1'b0, 4'd0,     32'h200,       32'h0,         32'h0,  32'h1122_AB44, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 4'd0,     32'hFFFC_0203, 32'h0,         32'h0,  32'h1122_AB44, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 4'd0,     32'h0,         32'h0,         32'h42, 32'h0,         32'h2408_0001};

    resetn = 1'b0; hold = 1'b0; data_en = 1'b0; inst_en = 1'b1; data_wen = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0; inst_addr = 32'd0; probe_idx = 8'h40;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_i_stall_comb", 32'(i_stall_w[0]), 32'd1);
    check("rst_d_stall", 32'(d_stall_w[0]), 32'd0);
    check("rst_inst_rdata", inst_rdata_w[0], 32'd0);
    check("rst_data_rdata", data_rdata_w[0], 32'd0);
    check("rst_ram_en", 32'(ram_en_w[0]), 32'd0);
    check("rst_ram_wen", 32'(ram_wen_w[0]), 32'd0);
    check("rst_ram_addr", 32'(ram_addr_w[0]), 32'd0);
    check("rst_ram_wdata", ram_wdata_w[0], 32'd0);
    inst_en = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;

    for (int v = 0; v < 6; v++)
      run_txn(vecs[v].den, vecs[v].ien, vecs[v].wen, vecs[v].daddr, vecs[v].wdata, vecs[v].iaddr,
              vecs[v].exp_d, vecs[v].exp_i);

    // Hold: results and flags frozen while longest_stall stays high, then an immediate restart.
    @(posedge clk); #1;
    data_en = 1'b1; data_wen = 4'd0; data_addr = 32'h100; hold = 1'b1;
    wait_all(64);
    r_hold = data_rdata_w[0]; base0 = en_cnt_w[0];
    check("hold_rdata_value", r_hold, 32'hCAFE_0100);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_d_stall", 32'(d_stall_w[0]), 32'd0);
      check("hold_data_rdata", data_rdata_w[0], r_hold);
    end
    check("hold_no_ram_en", en_cnt_w[0] - base0, 32'd0);
    @(posedge clk); #1 hold = 1'b0;
    @(negedge clk);
    check("release_same_cycle_d_stall", 32'(d_stall_w[0]), 32'd0);
    @(posedge clk); #1 hold = 1'b1;
    @(negedge clk);
    check("restart_d_stall", 32'(d_stall_w[0]), 32'd1);
    wait_all(64);
    check("restart_ram_en_count", en_cnt_w[0] - base0, 32'd1);
    @(posedge clk); #1 data_en = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);

    // Enable dropped one cycle into a fetch: the access still completes.
    #1 base0 = en_cnt_w[0]; inst_en = 1'b1; inst_addr = 32'h0;
    @(posedge clk); #1 inst_en = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    for (int g = 0; g < N; g++) check("en_drop_inst_rdata", inst_rdata_w[g], 32'h3C01_0000);
    check("en_drop_ram_en_count", en_cnt_w[0] - base0, 32'd1);

    // Reset during the wait states of a full-word write.
    @(posedge clk); #1;
    base0 = en_cnt_w[0];
    data_en = 1'b1; data_wen = 4'hF; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF; hold = 1'b1;
    @(posedge clk); #2 resetn = 1'b0;
    data_en = 1'b0; hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mid_ram_en", 32'(ram_en_w[0]), 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mid_no_strobe", en_cnt_w[0] - base0, 32'd0);
    for (int g = 0; g < N; g++) check("rst_mid_ram_unchanged", mem_probe_w[g], model[8'h40]);
    check("rst_mid_d_stall", 32'(d_stall_w[0]), 32'd0);
    check("rst_mid_data_rdata", data_rdata_w[0], 32'd0);

    // Random traffic against the word-array model.
    for (int t = 0; t < 25; t++) begin
      kind    = int'($urandom_range(0, 3));
      wen_r   = (kind == 2 || (kind == 3 && $urandom_range(0, 1) == 1)) ? 4'($urandom_range(1, 15)) : 4'd0;
      daddr_r = ($urandom & 32'hFFFC_0003) | {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      iaddr_r = ($urandom & 32'hFFFC_0003) | {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      exp_d   = model[daddr_r[9:2]];
      exp_i   = model[iaddr_r[9:2]];
      if (kind == 3 && wen_r != 4'd0 && daddr_r[9:2] == iaddr_r[9:2]) exp_i = merge(exp_i, $urandom, 4'd0) == exp_i ? merge(exp_i, daddr_r, 4'd0) : exp_i;
      if (kind == 3 && wen_r != 4'd0 && daddr_r[9:2] == iaddr_r[9:2]) exp_i = merge(model[iaddr_r[9:2]], 32'(t) * 32'h0101_0101, wen_r);
      run_txn(kind != 0, kind == 0 || kind == 3, wen_r, daddr_r, 32'(t) * 32'h0101_0101, iaddr_r, exp_d, exp_i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_like_responder.md
# sram_like_responder

Memory-side responder for the core's two sram-like ports: instruction fetch (`pcF`/`instr_enF`/`instrF`/`i_stall`) and data (`aluoutM`/`mem_enM`/`mem_wenM`/`mem_write_dataM`/`readdataM`/`d_stall`).
- Both ports are served from one single-ported, word-wide synchronous RAM, one access at a time, with a programmable wait-state count.
- The block generates `i_stall`/`d_stall` and holds completed results until the core's `longest_stall` falls.
- It sits between `mips` and the RAM model / SoC memory, replacing the cache path in uncached configurations.

## Interface
Parameters:
- `AW`, 16: RAM word-address width. Byte address bits `[AW+1:2]` are used; all other bits are ignored.
- `LAT`, 2: extra wait cycles before the RAM strobe. Legal range 0..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_en`  in  1  instruction request (core `instr_enF`).
- `inst_addr`  in  32  fetch byte address (core `pcF`).
- `inst_rdata`  out  32  fetched word (core `instrF`).
- `i_stall`  out  1  instruction port busy.
- `data_en`  in  1  data request (core `mem_enM`).
- `data_wen`  in  4  byte write enables; 0 means read.
- `data_addr`  in  32  data byte address (core `aluoutM`).
- `data_wdata`  in  32  write data.
- `data_rdata`  out  32  read word (core `readdataM`).
- `d_stall`  out  1  data port busy.
- `longest_stall`  in  1  core global stall; completed results are held while it is high.
- `ram_en`  out  1  RAM strobe.
- `ram_wen`  out  4  RAM byte write enables.
- `ram_addr`  out  AW  RAM word address.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data, valid the cycle after `ram_en`.

## Operation
FSM states: IDLE, WAIT, ACC, RESP.
- **Pending flags.** `d_pend = data_en & ~d_done`; `i_pend = inst_en & ~i_done`.
- **IDLE.**
  - If `d_pend`: latch the data address, wdata and wen; set `sel = D`.
  - Else if `i_pend`: latch the instruction address; set `sel = I`, wen = 0.
  - Next state is WAIT if `LAT > 0` (counter loaded with `LAT-1`), otherwise ACC.
- **WAIT.** Decrement the counter; go to ACC when it reaches 0.
- **ACC.** `ram_en = 1`; `ram_wen`/`ram_addr`/`ram_wdata` are driven from the latches. Go to RESP.
- **RESP.**
  - Capture `ram_rdata` into `data_rdata` (`sel = D`) or `inst_rdata` (`sel = I`).
  - Writes also capture `ram_rdata`, which is don't-care to the core.
  - Set `d_done` or `i_done`. Go to IDLE.
- **Arbitration.** Data has priority when both are pending in IDLE. There is no preemption: a request arriving during WAIT/ACC/RESP waits.
- **Stall outputs.** `i_stall = i_pend`, `d_stall = d_pend`. Both are combinational from the request inputs and the done flags.
- **Done flags.** `i_done`/`d_done` clear on any edge where `longest_stall == 0`; clearing has priority over setting in the same cycle. While a done flag is set:
  - its port is not re-served;
  - its stall output is 0;
  - its rdata is held.
- **Inputs during an access.** Address and data input changes after the IDLE latch are ignored until the access completes.
- **Unaligned addresses.** The low two address bits are ignored; no exception is raised here.

## Timing
- **Reset values.** All outputs 0, state IDLE, counter 0, done flags 0. Because the stall outputs are combinational, they may be 1 during reset if `inst_en`/`data_en` are high.
- **Latency.** A request seen in IDLE at cycle 0:
  - WAIT occupies cycles 1..LAT;
  - ACC is cycle LAT+1;
  - RESP is cycle LAT+2;
  - the done flag is set and the stall is low from cycle LAT+3.
  - The stall is therefore high for LAT+3 cycles.
- **Both ports pending at cycle 0.** Data completes as above. The instruction access starts in IDLE at cycle LAT+3, so `i_stall` falls at cycle 2·LAT+6.
- **Hold rule.** `inst_rdata`/`data_rdata` change only in RESP of their own port.
- **Back-to-back.** After `longest_stall` falls at edge N, a new request present at cycle N+1 starts in IDLE at cycle N+1; there is no idle bubble beyond that.
- **Reset mid-access.** The FSM goes asynchronously to IDLE and `ram_en` drops immediately. A partially counted access is abandoned and no RAM write occurs unless ACC had already been reached.
- **`en` dropped mid-access.** The access still completes and the done flag is set. The flag clears at the next edge with `longest_stall` low.

## Test plan
- **Single fetch.** LAT=2, RAM[0x40>>2]=0x2408_0001, `inst_en=1`, `inst_addr=0x40` at cycle 0 → `ram_en` at cycle 3 with `ram_addr=0x10`; `i_stall` high cycles 0–4, low at cycle 5; `inst_rdata=0x2408_0001`.
- **Simultaneous requests.** LAT=0, `data_en` (read 0x100) and `inst_en` (0x0) at cycle 0 → data served first, `d_stall` low at cycle 3, `i_stall` low at cycle 6; correct rdata on both ports.
- **Byte write then read.** `data_wen=4'b0010`, `data_wdata=0x0000_AB00` to 0x200 (old word 0x1122_3344), then a read of 0x200 → `data_rdata=0x1122_AB44`.
- **Hold.** `longest_stall` held high 10 cycles after the data done → `d_stall` stays 0, `data_rdata` stable, no further `ram_en`. Dropping `longest_stall` with `data_en` still high → a new access starts the next cycle.
- **Reset mid-access.** `resetn` low during WAIT of a write → `ram_en` never asserted and RAM unchanged. After release, all flags are 0 and the FSM is in IDLE.
- **LAT sweep.** LAT=0, 1, 15 → stall width = LAT+3 cycles in each case.
